demux_stream: RTL

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_stream.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/demux_stream.sv
// Stream demultiplexer: scatters input words into NCH lane registers, either by address or as sequential frames.
// Optional sequential/frame mode is compiled in when DEMUX_STREAM_SEQ_MODE_EN is defined.
module demux_stream #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [WIDTH-1:0]         inData,
    input  logic [$clog2(NCH)-1:0]   inSel,
    input  logic                     inMode,
    input  logic                     inClear,
    input  logic                     outFrameAck,
    output logic [NCH*WIDTH-1:0]     outData,
    output logic [NCH-1:0]           outLaneValid,
    output logic                     outFrameValid
);

    localparam int SEL_W = $clog2(NCH);

    // Lane storage shared by both build variants
    logic [NCH*WIDTH-1:0] r_data;
    logic [NCH-1:0]       r_lane_valid;
    logic [NCH*WIDTH-1:0] w_data_nxt;
    logic [NCH-1:0]       w_lane_valid_nxt;

    // Write request and clear request produced by the control section below
    logic                 w_wr_en;
    logic [SEL_W-1:0]     w_wr_lane;
    logic                 w_valid_clr;

`ifdef DEMUX_STREAM_SEQ_MODE_EN

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             r_frame_valid;
    logic             w_frame_valid_nxt;
    logic             w_ready;
    logic             w_xfer;

    assign w_ready = (r_state != S_FULL);
    assign w_xfer  = inValid && w_ready;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_frame_valid_nxt = r_frame_valid;
        w_wr_en           = 1'b0;
        w_wr_lane         = '0;
        w_valid_clr       = 1'b0;

        if (inClear) begin
            // Clear wins over acknowledge and drops any coincident transfer
            w_state_nxt       = S_IDLE;
            w_idx_nxt         = '0;
            w_frame_valid_nxt = 1'b0;
            w_valid_clr       = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        w_wr_en = 1'b1;
                        if (inMode) begin
                            w_wr_lane   = '0;
                            w_idx_nxt   = SEL_W'(1);
                            w_state_nxt = S_FILL;
                        end else begin
                            w_wr_lane = inSel;
                        end
                    end
                end
                S_FILL: begin
                    if (w_xfer) begin
                        w_wr_en   = 1'b1;
                        w_wr_lane = r_idx;
                        if (r_idx == SEL_W'(NCH - 1)) begin
                            w_idx_nxt         = '0;
                            w_state_nxt       = S_FULL;
                            w_frame_valid_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + SEL_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (outFrameAck) begin
                        w_state_nxt       = S_IDLE;
                        w_frame_valid_nxt = 1'b0;
                        w_valid_clr       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_valid <= w_frame_valid_nxt;
        end
    end

    assign inReady       = w_ready;
    assign outFrameValid = r_frame_valid;

`else

    // Addressed-only build: always ready, frame signalling absent
    always_comb begin
        w_wr_en     = inValid && !inClear;
        w_wr_lane   = inSel;
        w_valid_clr = inClear;
    end

    logic w_unused_ok;
    assign w_unused_ok   = ^{inMode, outFrameAck};

    assign inReady       = 1'b1;
    assign outFrameValid = 1'b0;

`endif

    // Lane 0 sits in the most significant slice of the flat data bus
    always_comb begin
        w_data_nxt       = r_data;
        w_lane_valid_nxt = w_valid_clr ? '0 : r_lane_valid;
        for (int k = 0; k < NCH; k++) begin
            if (w_wr_en && (w_wr_lane == SEL_W'(k))) begin
                w_data_nxt[(NCH-k)*WIDTH-1 -: WIDTH] = inData;
                w_lane_valid_nxt[k]                  = 1'b1;
            end
        end
    end

    // NOTE: the lane data registers are reset too, because the outputs must read zero after reset rather than stale data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data       <= '0;
            r_lane_valid <= '0;
        end else begin
            r_data       <= w_data_nxt;
            r_lane_valid <= w_lane_valid_nxt;
        end
    end

    assign outData      = r_data;
    assign outLaneValid = r_lane_valid;

endmodule
